vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive side of our 640x480@60 VGA timing: samples h_sync, v_sync and 8-bit RGB (3-3-2) on vga_clk.
- Aligns to the incoming sync timing, checks line and frame lengths against the expected totals, and declares lock after a run of clean frames.
- Once locked, emits a pixel stream with x/y coordinates, sof/eol markers and a valid strobe.
- Used for loopback verification of the generator and for frame-buffer write paths.

Parameters:
- H_TOTAL, 800: vga_clk cycles per line.
- H_DE_START, 144: cycles from line start to the first active pixel.
- H_ACTIVE, 640: active pixels per line.
- V_TOTAL, 525: lines per frame.
- V_DE_START, 35: lines from frame start to the first active line.
- V_ACTIVE, 480: active lines per frame.
- LOCK_FRAMES, 2: consecutive clean frames required for lock (1..15).

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- h_sync  in  1  horizontal sync, active-high pulse.
- v_sync  in  1  vertical sync, active-high pulse.
- din  in  8  pixel {r[2:0],g[2:0],b[1:0]}.
- pix_data  out  8  captured pixel.
- pix_x  out  10  column, 0..H_ACTIVE-1.
- pix_y  out  10  row, 0..V_ACTIVE-1.
- pix_valid  out  1  pix_data/x/y valid this cycle.
- sof  out  1  first pixel of frame (x=0,y=0), qualified by pix_valid.
- eol  out  1  last pixel of line (x=H_ACTIVE-1), qualified by pix_valid.
- locked  out  1  timing locked.
- err  out  1  one-cycle pulse when lock is lost.
- err_cnt  out  8  lock-loss count, saturates at 255.

Behaviour:
- Reset: every output is 0; all internal counters are 0; FSM is in SEARCH. Reset takes effect on the next vga_clk edge, including mid-frame.
- Input stage 1: h_sync, v_sync and din are registered (h1, v1, d1).
- Input stage 2: h1 is registered again (h2). h_rise = h1 & ~h2.
- h_pos (10-bit):
  - set to 0 on h_rise;
  - otherwise increments, saturating at 1023;
  - reaching 1023 is a timeout error.
- v_low flag: set whenever v1 is 0; cleared at frame start.
- Frame start: an h_rise with v1=1 and v_low=1. v_sync is therefore evaluated only at line starts, which tolerates skew between h_sync and v_sync.
- v_pos (10-bit):
  - set to 0 at frame start;
  - otherwise increments on each h_rise, saturating at 1023.
- Line check, at each h_rise after the first since SEARCH: h_pos+1 must equal H_TOTAL. A mismatch sets the frame_bad flag.
- Frame check, at frame start: v_pos+1 must equal V_TOTAL and frame_bad must be 0. frame_bad is then cleared.
- FSM:
  - SEARCH: wait for the first frame start, then go to CHECK with good=0. Line and frame checks before that point are ignored.
  - CHECK: at each frame start, a clean frame gives good+1 and a failing frame gives good=0. When good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked=1. Any failing line or frame check, or a timeout, goes to SEARCH. err pulses for 1 cycle and err_cnt increments (saturating).
  - A timeout in CHECK resets good to 0.
- Active region: h_pos in [H_DE_START, H_DE_START+H_ACTIVE-1] and v_pos in [V_DE_START, V_DE_START+V_ACTIVE-1].
- Output register, when state is LOCKED and the current h_pos/v_pos fall in the active region:
  - pix_valid=1, pix_data=d1;
  - pix_x = h_pos-H_DE_START, pix_y = v_pos-V_DE_START;
  - sof=1 when x=0 and y=0; eol=1 when x=H_ACTIVE-1.
- Latency: din to pix_data is 2 vga_clk cycles.
- Outside the active region or when not LOCKED: pix_valid, sof and eol are 0; pix_data, pix_x and pix_y hold their last values.
- Lock-loss cycle: pix_valid is forced to 0 in the same cycle err is asserted.
- Simultaneous events: frame start takes priority over a plain line increment. A reset asserted in the same cycle as any event wins.
- Arithmetic: all position arithmetic is unsigned 10-bit; comparisons use parameter values truncated to 10 bits.

Test Plan:
- Nominal lock: drive ideal 800x525 timing with h_sync high for cycles 0..95 of each line and v_sync high for lines 0..1 → locked rises at the start of frame 3. Then count exactly 640 pix_valid per line and 480 lines, with sof once per frame and eol 480 times per frame.
- Pixel mapping: din = (h_pos^v_pos)[7:0] → each valid beat has pix_data = ((pix_x+144)^(pix_y+35))[7:0], and pix_valid appears 2 cycles after the source cycle.
- Bad line: while locked, make one line 799 cycles long → err pulses once, err_cnt=1, locked=0 and pix_valid=0 in that cycle. Relock occurs after 2 further clean frames.
- Bad frame in CHECK: after the first frame start, send a 524-line frame → good resets and locked stays 0 until 2 consecutive clean frames follow.
- Sync loss: stop h_sync for 1100 cycles while locked → timeout at h_pos=1023, err pulses, state is SEARCH, and err_cnt saturates at 255 after repeated losses.
- Mid-frame reset: assert rst for 1 cycle at line 200 → all outputs 0 the next cycle, and lock is reacquired after the first frame start plus 2 clean frames.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA timing. Registers the incoming syncs
// and pixel bus, measures line and frame lengths against the expected totals,
// acquires lock after a run of clean frames and then emits a pixel stream
// with x/y coordinates and sof/eol markers.
//
// Output stream: pix_valid is a one-cycle strobe with no backpressure. When
// pix_valid is 1, pix_data/pix_x/pix_y/sof/eol describe one pixel and must be
// taken that cycle; when it is 0, sof/eol are 0 and the data fields hold.
module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int H_DE_START  = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_DE_START  = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [7:0] din,
  output logic [7:0] pix_data,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic       sof,
  output logic       eol,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt
);

  // All position arithmetic is 10-bit; limits are truncated to match.
  localparam logic [9:0] H_TOT10 = 10'(H_TOTAL);
  localparam logic [9:0] H_DS10  = 10'(H_DE_START);
  localparam logic [9:0] H_DE10  = 10'(H_DE_START + H_ACTIVE - 1);
  localparam logic [9:0] V_TOT10 = 10'(V_TOTAL);
  localparam logic [9:0] V_DS10  = 10'(V_DE_START);
  localparam logic [9:0] V_DE10  = 10'(V_DE_START + V_ACTIVE - 1);
  localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] good, good_nxt;
  logic       lose_lock;

  logic       h1, h2, v1;
  logic [7:0] d1;
  logic [9:0] h_pos, v_pos;
  logic       v_low, frame_bad, seen_rise;

  logic h_rise, frame_start, timeout, line_err, frame_ok, active, pix_go;

  // Event decode. v_sync is only looked at on a line start, so skew between
  // the two syncs does not matter.
  assign h_rise      = h1 & ~h2;
  assign frame_start = h_rise & v1 & v_low;
  assign timeout     = ~h_rise & (h_pos == 10'h3FF);
  assign line_err    = h_rise & seen_rise & ((h_pos + 10'd1) != H_TOT10);
  assign frame_ok    = ((v_pos + 10'd1) == V_TOT10) & ~frame_bad & ~line_err;
  assign active      = (h_pos >= H_DS10) && (h_pos <= H_DE10) &&
                       (v_pos >= V_DS10) && (v_pos <= V_DE10);
  assign pix_go      = (state == LOCKED) & active & ~lose_lock;
  assign locked      = (state == LOCKED);

  // Input registers: two stages on h_sync for edge detect, one on the rest.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h1 <= 1'b0;
      h2 <= 1'b0;
      v1 <= 1'b0;
      d1 <= 8'd0;
    end else begin
      h1 <= h_sync;
      h2 <= h1;
      v1 <= v_sync;
      d1 <= din;
    end
  end

  // Position counters and frame bookkeeping flags.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h_pos     <= 10'd0;
      v_pos     <= 10'd0;
      v_low     <= 1'b0;
      frame_bad <= 1'b0;
      seen_rise <= 1'b0;
    end else begin
      if (h_rise)                h_pos <= 10'd0;
      else if (h_pos != 10'h3FF) h_pos <= h_pos + 10'd1;

      if (frame_start)                    v_pos <= 10'd0;
      else if (h_rise && v_pos != 10'h3FF) v_pos <= v_pos + 10'd1;

      if (frame_start) v_low <= 1'b0;
      else if (!v1)    v_low <= 1'b1;

      if (frame_start)   frame_bad <= 1'b0;
      else if (line_err) frame_bad <= 1'b1;

      // The first line start seen in SEARCH has no previous line to measure.
      if (state == SEARCH) seen_rise <= h_rise;
      else if (h_rise)     seen_rise <= 1'b1;
    end
  end

  // FSM state and clean-frame counter register.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state <= SEARCH;
      good  <= 4'd0;
    end else begin
      state <= state_nxt;
      good  <= good_nxt;
    end
  end

  // FSM next state: SEARCH waits for a frame start, CHECK counts clean
  // frames, LOCKED drops back to SEARCH on any timing fault.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    lose_lock = 1'b0;
    case (state)
      SEARCH: begin
        if (frame_start) begin
          state_nxt = CHECK;
          good_nxt  = 4'd0;
        end
      end
      CHECK: begin
        if (timeout) begin
          good_nxt = 4'd0;
        end else if (frame_start) begin
          if (frame_ok) begin
            good_nxt = good + 4'd1;
            if ((good + 4'd1) == LOCK_N) state_nxt = LOCKED;
          end else begin
            good_nxt = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (line_err || timeout || (frame_start && !frame_ok)) begin
          state_nxt = SEARCH;
          lose_lock = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Pixel output register plus lock-loss pulse and saturating loss counter.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      pix_data  <= 8'd0;
      pix_x     <= 10'd0;
      pix_y     <= 10'd0;
      pix_valid <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      pix_valid <= pix_go;
      sof       <= pix_go & (h_pos == H_DS10) & (v_pos == V_DS10);
      eol       <= pix_go & (h_pos == H_DE10);
      if (pix_go) begin
        pix_data <= d1;
        pix_x    <= h_pos - H_DS10;
        pix_y    <= v_pos - V_DS10;
      end
      err <= lose_lock;
      if (lose_lock && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives scaled-down VGA timing into vga_capture, frame by
// frame from a table of frame descriptions, and checks lock, loss reporting
// and the pixel stream.
module tb_vga_capture;

  localparam int H_TOTAL     = 12;
  localparam int H_DE_START  = 3;
  localparam int H_ACTIVE    = 8;
  localparam int V_TOTAL     = 5;
  localparam int V_DE_START  = 2;
  localparam int V_ACTIVE    = 2;
  localparam int LOCK_FRAMES = 2;
  localparam int HSW         = 2;   // h_sync high for cycles 0..HSW-1
  localparam int VSW         = 2;   // v_sync high for lines 0..VSW-1
  localparam int RST_S       = 6;   // cycle within the line where rst is pulsed

  // ---------------- clock / reset ----------------
  logic       vga_clk = 1'b0;
  logic       rst;
  logic       h_sync, v_sync;
  logic [7:0] din;
  logic [7:0] pix_data;
  logic [9:0] pix_x, pix_y;
  logic       pix_valid, sof, eol, locked, err;
  logic [7:0] err_cnt;

  always #5 vga_clk = ~vga_clk;

  vga_capture #(
    .H_TOTAL(H_TOTAL), .H_DE_START(H_DE_START), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_DE_START(V_DE_START), .V_ACTIVE(V_ACTIVE),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .vga_clk(vga_clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync), .din(din),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .sof(sof), .eol(eol), .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  // One frame to drive, plus what must be seen at its line-0 start point
  // (after the frame-start edge) about lock, loss count and the previous
  // frame's output window.
  typedef struct {
    int nlines;
    int bad_line;    // line driven one cycle short, -1 for none
    int rst_line;    // line in which rst is pulsed at RST_S, -1 for none
    bit sb_en;       // push expected pixels of this frame to the scoreboard
    bit chk_win;     // compare previous window counts
    bit exp_locked;
    int exp_errc;
    int pv_valid;
    int pv_sof;
    int pv_eol;
    int pv_err;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int win_valid = 0, win_sof = 0, win_eol = 0, win_err = 0;
  int prev_len;
  int first_err_g;
  logic [27:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_data"}, 32'(pix_data), 0);
    check({tag, "_pix_x"}, 32'(pix_x), 0);
    check({tag, "_pix_y"}, 32'(pix_y), 0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 0);
    check({tag, "_sof"}, 32'(sof), 0);
    check({tag, "_eol"}, 32'(eol), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge vga_clk) begin
    logic [27:0] e;
    if (pix_valid === 1'b1) begin
      win_valid++;
      check("pix_data_map", 32'(pix_data),
            32'(8'((32'(pix_x) + H_DE_START) ^ (32'(pix_y) + V_DE_START))));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_pixel", {4'd0, pix_x, pix_y, pix_data}, {4'd0, e});
      end
    end
    if (sof === 1'b1) begin
      win_sof++;
      check("sof_pos", {12'd0, pix_x, pix_y}, 0);
      check("sof_qual", 32'(pix_valid), 1);
    end
    if (eol === 1'b1) begin
      win_eol++;
      check("eol_pos", 32'(pix_x), H_ACTIVE - 1);
    end
    if (err === 1'b1) begin
      win_err++;
      check("err_locked", 32'(locked), 0);
      check("err_valid", 32'(pix_valid), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic h, input logic v, input logic [7:0] d);
    h_sync = h;
    v_sync = v;
    din    = d;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frame_start_checks(input vec_t v);
    check("locked_at_frame", 32'(locked), 32'(v.exp_locked));
    check("err_cnt_at_frame", 32'(err_cnt), 32'(v.exp_errc));
    if (v.chk_win) begin
      check("win_valid", win_valid, v.pv_valid);
      check("win_sof", win_sof, v.pv_sof);
      check("win_eol", win_eol, v.pv_eol);
      check("win_err", win_err, v.pv_err);
      check("sb_drained", exp_q.size(), 0);
    end
    win_valid = 0;
    win_sof   = 0;
    win_eol   = 0;
    win_err   = 0;
  endtask

  // din is tagged with the receiver's own position at the moment the sample
  // sits in its input register: cycle s of a line is seen at h_pos = s-1.
  task automatic drive_line(input int len, input int line, input bit vs,
                            input int rst_at, input bit sb, input vec_t v);
    int hp, lp;
    logic [7:0] d;
    for (int s = 0; s < len; s++) begin
      hp = (s == 0) ? prev_len - 1 : s - 1;
      lp = (s == 0) ? line - 1 : line;
      d  = 8'(hp ^ lp);
      if (sb && lp >= V_DE_START && lp < V_DE_START + V_ACTIVE &&
          hp >= H_DE_START && hp < H_DE_START + H_ACTIVE)
        exp_q.push_back({10'(hp - H_DE_START), 10'(lp - V_DE_START), d});
      rst = (s == rst_at);
      tick(s < HSW, vs, d);
      if (s == rst_at) begin
        rst = 1'b0;
        check_zero("midframe_rst");
      end
      if (line == 0 && s == 1) frame_start_checks(v);
    end
    prev_len = len;
  endtask

  task automatic drive_frame(input vec_t v);
    for (int l = 0; l < v.nlines; l++)
      drive_line((l == v.bad_line) ? H_TOTAL - 1 : H_TOTAL, l, l < VSW,
                 (l == v.rst_line) ? RST_S : -1, v.sb_en, v);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[14];
  vec_t f14, f1, f2, f3, nochk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; h_sync = 1'b0; v_sync = 1'b0; din = 8'd0;
    prev_len = H_TOTAL;
    first_err_g = -1;

    //            nl bad rst sb cw lk errc val sof eol err
    tbl[0]  = '{5, -1, -1, 0, 1, 0, 0,  0, 0, 0, 0};  // first frame start: CHECK
    tbl[1]  = '{5, -1, -1, 0, 1, 0, 0,  0, 0, 0, 0};  // good=1
    tbl[2]  = '{5, -1, -1, 1, 1, 1, 0,  0, 0, 0, 0};  // locked at 3rd frame start
    tbl[3]  = '{5,  2, -1, 0, 1, 1, 0, 16, 1, 2, 0};  // line 2 one cycle short
    tbl[4]  = '{5, -1, -1, 0, 1, 0, 1,  7, 1, 0, 1};  // lost lock, relock begins
    tbl[5]  = '{4, -1, -1, 0, 1, 0, 1,  0, 0, 0, 0};  // 4-line frame while in CHECK
    tbl[6]  = '{5, -1, -1, 0, 1, 0, 1,  0, 0, 0, 0};  // good cleared
    tbl[7]  = '{5, -1, -1, 0, 1, 0, 1,  0, 0, 0, 0};  // good=1
    tbl[8]  = '{5, -1, -1, 1, 1, 1, 1,  0, 0, 0, 0};  // relocked
    tbl[9]  = '{5, -1, -1, 0, 1, 1, 1, 16, 1, 2, 0};
    tbl[10] = '{5, -1,  3, 0, 1, 1, 1, 16, 1, 2, 0};  // rst pulse mid line 3
    tbl[11] = '{5, -1, -1, 0, 1, 0, 0,  9, 1, 1, 0};  // first frame start after rst
    tbl[12] = '{5, -1, -1, 0, 1, 0, 0,  0, 0, 0, 0};
    tbl[13] = '{5, -1, -1, 1, 1, 1, 0,  0, 0, 0, 0};  // locked again
    f14     = '{3, -1, -1, 0, 1, 1, 0, 16, 1, 2, 0};
    nochk   = '{0, -1, -1, 0, 0, 0, 0,  0, 0, 0, 0};

    repeat (3) @(posedge vga_clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Tail of a frame with v_sync low so the first full frame is recognised.
    for (int l = 2; l < V_TOTAL; l++) drive_line(H_TOTAL, l, 1'b0, -1, 1'b0, nochk);

    for (int i = 0; i < 14; i++) drive_frame(tbl[i]);

    // Sync loss: three normal lines, then h_sync stops for 1100 cycles.
    // Last line start is 12 cycles before the gap; h_pos reaches 1023 on the
    // 1024th edge after that line's first edge, err shows one edge later.
    drive_frame(f14);
    for (int g = 0; g < 1100; g++) begin
      tick(1'b0, 1'b0, 8'h00);
      if (err === 1'b1 && first_err_g < 0) first_err_g = g;
    end
    check("timeout_err_cycle", first_err_g, 1025 - H_TOTAL);
    check("timeout_err_pulses", win_err, 1);
    check("timeout_locked", 32'(locked), 0);
    check("timeout_err_cnt", 32'(err_cnt), 1);
    prev_len = H_TOTAL;

    // Repeated lock/loss cycles drive err_cnt into saturation.
    for (int i = 0; i < 255; i++) begin
      int ec;
      ec = (i + 1 > 255) ? 255 : i + 1;
      f1 = '{5, -1, -1, 0, 0, 0, ec, 0, 0, 0, 0};
      f2 = '{5, -1, -1, 0, 0, 0, ec, 0, 0, 0, 0};
      f3 = '{5,  1, -1, 0, 0, 1, ec, 0, 0, 0, 0};
      drive_frame(f1);
      drive_frame(f2);
      drive_frame(f3);
    end
    check("sat_err_cnt", 32'(err_cnt), 255);
    check("sat_locked", 32'(locked), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
